// File: rtl/buzzer_pkg.sv
// Shared types and cadence constants for the two-channel proximity buzzer driver.
// Cadence per urgency: level 1 = 20/80 ticks, level 2 = 10/20 ticks, level 3 = continuous.
package buzzer_pkg;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    CONT = 2'd3
  } state_t;

  localparam int PHASE_W = 7;

  localparam logic [PHASE_W-1:0] L1_ON_TICKS  = 7'd20;
  localparam logic [PHASE_W-1:0] L1_OFF_TICKS = 7'd80;
  localparam logic [PHASE_W-1:0] L2_ON_TICKS  = 7'd10;
  localparam logic [PHASE_W-1:0] L2_OFF_TICKS = 7'd20;

  localparam level_t LEVEL_NONE = 2'd0;
  localparam level_t LEVEL_CONT = 2'd3;

  typedef struct packed {
    state_t               state;
    level_t               cur_level;
    logic [PHASE_W-1:0]   phase;
  } chan_t;

  localparam chan_t CHAN_IDLE = '{state: IDLE, cur_level: LEVEL_NONE, phase: '0};

  function automatic logic [PHASE_W-1:0] on_last(input level_t lvl);
    return (lvl == 2'd2) ? L2_ON_TICKS - 7'd1 : L1_ON_TICKS - 7'd1;
  endfunction

  function automatic logic [PHASE_W-1:0] off_last(input level_t lvl);
    return (lvl == 2'd2) ? L2_OFF_TICKS - 7'd1 : L1_OFF_TICKS - 7'd1;
  endfunction

  // Where a channel lands when it (re)starts on a requested level.
  function automatic chan_t enter(input level_t lvl);
    chan_t c;
    c = CHAN_IDLE;
    if (lvl == LEVEL_CONT) begin
      c.state     = CONT;
      c.cur_level = LEVEL_CONT;
    end else if (lvl != LEVEL_NONE) begin
      c.state     = ON;
      c.cur_level = lvl;
    end
    return c;
  endfunction

endpackage

// File: rtl/buzz_channel.sv
// One buzzer channel: cadence FSM with latched level and tick phase counter,
// plus the registered envelope and tone drive for that side.
module buzz_channel
  import buzzer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] level,
  input  logic       tick,
  input  logic       tone,
  output logic       buzz,
  output logic       active
);

  chan_t ch;
  chan_t ch_nxt;
  logic  sounding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch <= CHAN_IDLE;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      ch <= ch_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns ch_nxt and no latch is inferred.
    ch_nxt = ch;
    if (!enable) begin
      ch_nxt = CHAN_IDLE;
    end else begin
      unique case (ch.state)
        IDLE: ch_nxt = enter(level);
        ON: begin
          if (level > ch.cur_level) begin
            ch_nxt = enter(level);
          end else if (tick && ch.phase == on_last(ch.cur_level)) begin
            ch_nxt.state = OFF;
            ch_nxt.phase = '0;
          end else if (tick) begin
            ch_nxt.phase = ch.phase + 7'd1;
          end
        end
        OFF: begin
          // Escalation restarts now; anything else waits for the period to close.
          if (level > ch.cur_level || (tick && ch.phase == off_last(ch.cur_level))) begin
            ch_nxt = enter(level);
          end else if (tick) begin
            ch_nxt.phase = ch.phase + 7'd1;
          end
        end
        CONT: begin
          if (level != LEVEL_CONT) ch_nxt = enter(level);
        end
        default: ch_nxt = CHAN_IDLE;
      endcase
    end
  end

  assign sounding = (ch.state == ON) || (ch.state == CONT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      buzz   <= 1'b0;
    end else begin
      active <= sounding && enable;
      buzz   <= sounding && tone && enable;
    end
  end

endmodule

// File: rtl/buzzer_driver.sv
// Two-channel piezo driver: shared tone and cadence-tick generators feeding two channel FSMs.
// Optional build macro INPUT_SYNC_EN adds 2-flop synchronizers on enable and both level inputs.
module buzzer_driver
  import buzzer_pkg::*;
#(
  parameter int TONE_HALF = 25000,
  parameter int TICK_DIV  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] left_level,
  input  logic [1:0] right_level,
  output logic       buzz_left,
  output logic       buzz_right,
  output logic       active_left,
  output logic       active_right
);

  localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TONE_W-1:0] tone_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tone;
  logic              tick;
  logic              en_i;
  level_t            left_i;
  level_t            right_i;

`ifdef INPUT_SYNC_EN
  logic [4:0] sync_a;
  logic [4:0] sync_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {enable, left_level, right_level};
      sync_b <= sync_a;
    end
  end

  assign en_i    = sync_b[4];
  assign left_i  = sync_b[3:2];
  assign right_i = sync_b[1:0];
`else
  assign en_i    = enable;
  assign left_i  = left_level;
  assign right_i = right_level;
`endif

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Both generators free-run regardless of enable so cadence phase is never disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      if (tone_cnt == TONE_W'(TONE_HALF - 1)) begin
        tone_cnt <= '0;
        tone     <= ~tone;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  buzz_channel u_left (
    .clk    (clk),
    .rst    (rst),
    .enable (en_i),
    .level  (left_i),
    .tick   (tick),
    .tone   (tone),
    .buzz   (buzz_left),
    .active (active_left)
  );

  buzz_channel u_right (
    .clk    (clk),
    .rst    (rst),
    .enable (en_i),
    .level  (right_i),
    .tick   (tick),
    .tone   (tone),
    .buzz   (buzz_right),
    .active (active_right)
  );

endmodule

// File: tb/tb_buzzer_driver.sv
// Table-driven bench for buzzer_driver (TONE_HALF=4, TICK_DIV=10): each row drives inputs at a
// cycle and schedules an expected {active_left, active_right, buzz_left, buzz_right} for a later cycle.
module tb_buzzer_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] left_level = 2'd0;
  logic [1:0] right_level = 2'd0;
  logic       buzz_left;
  logic       buzz_right;
  logic       active_left;
  logic       active_right;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         at;
    logic       en;
    logic [1:0] l;
    logic [1:0] r;
    int         due;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    int         due;
    logic [3:0] exp;
  } exp_t;

  vec_t  tbl[$];
  exp_t  exp_q[$];
  string scen;

  buzzer_driver #(.TONE_HALF(4), .TICK_DIV(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .left_level   (left_level),
    .right_level  (right_level),
    .buzz_left    (buzz_left),
    .buzz_right   (buzz_right),
    .active_left  (active_left),
    .active_right (active_right)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {active_left, active_right, buzz_left, buzz_right};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got {al,ar,bl,br}=%b expected %b", name, got, exp);
    end
  endtask

  function automatic void add(input int at, input logic en, input logic [1:0] l,
                              input logic [1:0] r, input int due, input logic [3:0] exp);
    vec_t v;
    v.at = at; v.en = en; v.l = l; v.r = r; v.due = due; v.exp = exp;
    tbl.push_back(v);
  endfunction

  // Cycle c = number of rising edges since reset release; work happens on the falling edge.
  task automatic run_tbl(input bit do_reset, input int max_cyc);
    int idx;
    idx = 0;
    if (do_reset) begin
      rst = 1'b1; enable = 1'b0; left_level = 2'd0; right_level = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
    for (int c = 0; c <= max_cyc; c++) begin
      while (idx < tbl.size() && tbl[idx].at == c) begin
        exp_t e;
        enable      = tbl[idx].en;
        left_level  = tbl[idx].l;
        right_level = tbl[idx].r;
        e.name = $sformatf("%s@%0d", scen, tbl[idx].due);
        e.due  = tbl[idx].due;
        e.exp  = tbl[idx].exp;
        exp_q.push_back(e);
        idx++;
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due == c) begin
          check(exp_q[i].name, outs(), exp_q[i].exp);
          exp_q.delete(i);
        end
      end
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: never compared, run ended at cycle %0d before due %0d",
               exp_q[0].name, max_cyc, exp_q[0].due);
      exp_q.delete(0);
    end
    tbl.delete();
  endtask

  initial begin
    // Level 1 held left: 200 on / 800 off after a 199-cycle first burst, tone every 4 cycles.
    scen = "lvl1_left";
    add(0, 1, 1, 0,    0, 4'b0000); add(0, 1, 1, 0,    1, 4'b0000);
    add(0, 1, 1, 0,    2, 4'b1000); add(0, 1, 1, 0,    4, 4'b1000);
    add(0, 1, 1, 0,    5, 4'b1010); add(0, 1, 1, 0,    8, 4'b1010);
    add(0, 1, 1, 0,    9, 4'b1000); add(0, 1, 1, 0,  200, 4'b1010);
    add(0, 1, 1, 0,  201, 4'b0000); add(0, 1, 1, 0, 1000, 4'b0000);
    add(0, 1, 1, 0, 1001, 4'b1000); add(0, 1, 1, 0, 1005, 4'b1010);
    add(0, 1, 1, 0, 1200, 4'b1010); add(0, 1, 1, 0, 1201, 4'b0000);
    add(0, 1, 1, 0, 2001, 4'b1000);
    run_tbl(1, 2005);

    // Right level 2, escalate to 3 mid-OFF, later back to 2.
    scen = "esc_right";
    add(0,   1, 0, 2,   0, 4'b0000); add(0,   1, 0, 2,   2, 4'b0100);
    add(0,   1, 0, 2, 100, 4'b0100); add(0,   1, 0, 2, 101, 4'b0000);
    add(150, 1, 0, 3, 151, 4'b0000); add(150, 1, 0, 3, 152, 4'b0101);
    add(150, 1, 0, 3, 161, 4'b0100); add(400, 1, 0, 2, 401, 4'b0100);
    add(400, 1, 0, 2, 500, 4'b0100); add(400, 1, 0, 2, 501, 4'b0000);
    add(400, 1, 0, 2, 700, 4'b0000); add(400, 1, 0, 2, 701, 4'b0101);
    add(400, 1, 0, 2, 800, 4'b0101); add(400, 1, 0, 2, 801, 4'b0000);
    run_tbl(1, 805);

    // Left level 2 reduced to 1 mid-ON: 100/200 period completes, then 200/800.
    scen = "deesc_left";
    add(0,  1, 2, 0,    2, 4'b1000); add(50, 1, 1, 0,  100, 4'b1000);
    add(50, 1, 1, 0,  101, 4'b0000); add(50, 1, 1, 0,  300, 4'b0000);
    add(50, 1, 1, 0,  301, 4'b1010); add(50, 1, 1, 0,  500, 4'b1000);
    add(50, 1, 1, 0,  501, 4'b0000); add(50, 1, 1, 0, 1300, 4'b0000);
    add(50, 1, 1, 0, 1301, 4'b1010);
    run_tbl(1, 1305);

    // Both at level 1; left drops to 0 mid-ON and goes IDLE after OFF, right keeps its cadence.
    scen = "stop_left";
    add(0,   1, 1, 1,    2, 4'b1100); add(0,   1, 1, 1,    5, 4'b1111);
    add(100, 1, 0, 1,  200, 4'b1111); add(100, 1, 0, 1,  201, 4'b0000);
    add(100, 1, 0, 1, 1000, 4'b0000); add(100, 1, 0, 1, 1001, 4'b0100);
    add(100, 1, 0, 1, 1005, 4'b0101); add(100, 1, 0, 1, 1201, 4'b0000);
    add(100, 1, 0, 1, 1500, 4'b0000); add(100, 1, 0, 1, 2001, 4'b0100);
    run_tbl(1, 2005);

    // Enable dropped mid-CONT, restored; tick phase must survive the gap.
    scen = "enable";
    add(0,   1, 3, 3,   2, 4'b1100); add(0,   1, 3, 3,   5, 4'b1111);
    add(50,  0, 3, 3,  50, 4'b1100); add(50,  0, 3, 3,  51, 4'b0000);
    add(55,  1, 3, 3,  56, 4'b0000); add(55,  1, 3, 3,  57, 4'b1100);
    add(55,  1, 3, 3,  61, 4'b1111); add(100, 1, 1, 1, 101, 4'b1111);
    add(100, 1, 1, 1, 300, 4'b1100); add(100, 1, 1, 1, 301, 4'b0000);
    run_tbl(1, 305);

    // Asynchronous reset between edges mid-pattern, then restart from IDLE.
    scen = "pre_rst";
    add(0, 1, 3, 1, 2, 4'b1100); add(0, 1, 3, 1, 30, 4'b1111);
    run_tbl(1, 33);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", outs(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    scen = "post_rst";
    add(0, 1, 3, 1,   0, 4'b0000); add(0, 1, 3, 1,   1, 4'b0000);
    add(0, 1, 3, 1,   2, 4'b1100); add(0, 1, 3, 1,   5, 4'b1111);
    add(0, 1, 3, 1, 200, 4'b1111); add(0, 1, 3, 1, 201, 4'b1000);
    run_tbl(0, 205);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
